// File: rtl/iterative_shifter_if.sv
// Start/done handshake bundle for the iterative shifter.
//   start   : request, honoured only while the shifter is idle
//   mode    : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   data_in : operand
//   shamt   : shift amount, 0..WIDTH-1
//   busy    : shifter is not idle
//   done    : one-cycle completion pulse
//   result  : shifted value, held until the next completion or reset
// master = requester (control FSM / bench), slave = shifter.
interface iterative_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, mode, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit: SLL, SRL, SRA, ROR, up to STEP positions per clock.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : iterative_shifter_if slave (start/mode/data_in/shamt in,
//           busy/done/result out)
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// SHIFT | shifting the working register until remaining count is zero
// DONE  | done pulse cycle; returns to IDLE on the next edge
module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  iterative_shifter_if.slave  bus
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // When STEP >= WIDTH the per-cycle limit never binds, since the remaining
  // count is at most WIDTH-1; saturating the constant keeps it in SHW bits.
  localparam logic [SHW-1:0] STEP_K  = (STEP >= WIDTH) ? {SHW{1'b1}} : SHW'(STEP);
  localparam logic [SHW:0]   WIDTH_C = (SHW + 1)'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   remaining;
  logic [1:0]       mode_q;
  logic             sign_q;
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  logic [SHW-1:0]   k;
  logic [SHW:0]     ror_back;
  logic [WIDTH-1:0] fill_hi;
  logic [WIDTH-1:0] shifted;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (remaining == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One step of the shift: k = min(STEP, remaining).
  always_comb begin
    k        = (remaining >= STEP_K) ? STEP_K : remaining;
    ror_back = WIDTH_C - {1'b0, k};
    // Ones in the top k bit positions, used as the SRA sign fill.
    fill_hi  = ~({WIDTH{1'b1}} >> k);
    shifted  = work;
    case (mode_q)
      MODE_SLL: shifted = work << k;
      MODE_SRL: shifted = work >> k;
      MODE_SRA: shifted = (work >> k) | (sign_q ? fill_hi : '0);
      MODE_ROR: shifted = (work >> k) | (work << ror_back);
      default:  shifted = work;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      work      <= '0;
      remaining <= '0;
      mode_q    <= '0;
      sign_q    <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work      <= bus.data_in;
            remaining <= bus.shamt;
            mode_q    <= bus.mode;
            sign_q    <= bus.data_in[WIDTH-1];
          end
        end
        SHIFT: begin
          if (remaining != '0) begin
            work      <= shifted;
            remaining <= remaining - k;
          end else begin
            result_q <= work;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule
